// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified RAM port between the instruction-fetch
// requester and the data-memory requester. Data wins by default because a
// stalled memory stage freezes the pipeline; a saturating streak counter
// forces a fetch grant after MAX_DSTREAK data grants taken while a fetch
// was waiting.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DSTREAK);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_dstreak;
  logic [CNT_W-1:0] w_dstreakNext;
  logic             w_dataReq;
  logic             w_forceFetch;

  assign w_dataReq    = dREN | dWEN;
  assign w_forceFetch = iREN & (r_dstreak == MAX_CNT);

  // State and starvation counter; reset returns to IDLE and forgets any streak.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_dstreak <= w_dstreakNext;
    end
  end

  // Arbitration, RAM drive and requester handshakes; everything idles while reset is low.
  always_comb begin
    w_stateNext   = r_state;
    w_dstreakNext = r_dstreak;
    iwait         = 1'b1;
    dwait         = 1'b1;
    iload         = '0;
    dload         = '0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;

    if (nRST) begin
      case (r_state)
        IDLE: begin
          if (w_dataReq && !w_forceFetch) begin
            w_stateNext = GNT_D;
          end else if (iREN) begin
            w_stateNext = GNT_I;
          end
        end

        GNT_I: begin
          if (!iREN) begin
            w_stateNext = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ramstate == RAM_ACCESS) begin
              iwait         = 1'b0;
              iload         = ramload;
              w_dstreakNext = '0;
              w_stateNext   = IDLE;
            end else if (ramstate == RAM_ERROR) begin
              w_stateNext = IDLE;
            end
          end
        end

        GNT_D: begin
          if (!w_dataReq) begin
            w_stateNext = IDLE;
          end else begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (dWEN) begin
              ramWEN = 1'b1;
            end else begin
              ramREN = 1'b1;
            end
            if (ramstate == RAM_ACCESS) begin
              dwait       = 1'b0;
              dload       = ramload;
              w_stateNext = IDLE;
              if (iREN) begin
                w_dstreakNext = (r_dstreak == MAX_CNT) ? MAX_CNT : r_dstreak + ONE_CNT;
              end else begin
                w_dstreakNext = '0;
              end
            end else if (ramstate == RAM_ERROR) begin
              w_stateNext = IDLE;
            end
          end
        end

        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between the instruction-fetch requester (icache/fetch stage) and the data-memory requester (dcache/memory stage).
- One granted transaction at a time; wait handshake back to each requester.
- Data has priority because a stalled memory stage freezes the whole pipeline; a bounded starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width (word_t)
- DATA_W, 32, data width (word_t)
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  high = instruction not yet served
- iload  out  DATA_W  instruction data, valid when iwait low
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  high = data access not yet served
- dload  out  DATA_W  read data, valid when dwait low
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock CLK; reset nRST is synchronous and active-low. Single clock domain.
- States: IDLE, GNT_I, GNT_D. State register, dstreak counter (clog2(MAX_DSTREAK+1) bits), all sampled on posedge CLK.
- Reset: state=IDLE, dstreak=0. Combinational outputs during and after reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0. Reset mid-grant aborts the transaction; no completion is signalled.
- IDLE:
  - RAM enables are 0.
  - Next state is GNT_D if (dREN|dWEN) and not (iREN & dstreak==MAX_DSTREAK). Otherwise GNT_I if iREN. Otherwise IDLE.
  - Arbitration therefore costs exactly one cycle.
- GNT_I:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 and iload=ramload that cycle, dstreak<=0, next IDLE.
- GNT_D:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0 (write wins when both enables are set). Else ramREN=1.
  - When ramstate==ACCESS: dwait=0 and dload=ramload that cycle, next IDLE.
  - On that completion, dstreak<=min(dstreak+1, MAX_DSTREAK) if iREN, else dstreak<=0.
- Wait signals:
  - iwait=1 in every cycle except the ACCESS cycle of GNT_I.
  - dwait=1 in every cycle except the ACCESS cycle of GNT_D.
  - iwait and dwait are never both 0 in the same cycle.
- ramstate BUSY or FREE while granted: hold state, hold RAM signals, keep the wait asserted.
- ramstate ERROR while granted: next IDLE, wait stays high, dstreak unchanged. The requester is re-arbitrated and retries.
- Requester drops its request while granted (e.g. fetch_p flush): next IDLE, RAM enables drop in that same cycle (outputs are combinational from state and request), no completion.
- Latency: a request in IDLE with a RAM that answers ACCESS on the first grant cycle completes 2 cycles after the request is raised.
- Back-to-back: after a completion the arbiter returns to IDLE for one cycle. Minimum throughput is therefore one access per 2 cycles plus RAM latency.

Test Plan:
- Reset: nRST=0 for 2 cycles with iREN=dREN=1 → iwait=dwait=1, ramREN=ramWEN=0, state IDLE. Release → GNT_D is entered on the next edge.
- Lone fetch: iREN=1, iaddr=0x0000_0040, RAM gives BUSY for 2 cycles then ACCESS with ramload=0x2008_0001 → ramREN=1 and ramaddr=0x40 from cycle 1. iwait falls only in cycle 3 with iload=0x2008_0001.
- Simultaneous: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF → data granted first: ramWEN=1, ramstore=0xDEADBEEF. Fetch is served in the next grant; dwait/iwait are never both low.
- Starvation: iREN held, dREN re-raised every IDLE, MAX_DSTREAK=4 → exactly 4 data completions, then a GNT_I completion, then dstreak=0 and data wins again.
- Abort and error: grant a data read, drop dREN while BUSY → next IDLE, no dwait pulse. A separate grant receiving ERROR → IDLE, retry, completes on a subsequent ACCESS.
- dREN=dWEN=1 together → ramWEN=1, ramREN=0 for the whole grant.
